// File: rtl/bus_transfer_arbiter.sv
// Round-robin arbiter/sequencer for the shared 8-bit system bus: grants one source,
// drives its bus enable, then strobes the destination load. Optional macro BUS_ARB_SETTLE_EN adds a DRIVE cycle.
module bus_transfer_arbiter #(
  parameter  int NUM_SRC = 4,
  parameter  int NUM_DST = 8,
  parameter  int DST_W   = 3,
  localparam int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     iClk,
  input  logic                     iReset,
  input  logic [NUM_SRC-1:0]       iReq,
  input  logic [NUM_SRC*DST_W-1:0] iDst,
  output logic [NUM_SRC-1:0]       oEnable,
  output logic [NUM_DST-1:0]       oLoad,
  output logic [NUM_SRC-1:0]       oAck,
  output logic                     oBusy,
  output logic [ID_W-1:0]          oGrantId
);

  localparam logic [1:0] IDLE  = 2'd0;
`ifdef BUS_ARB_SETTLE_EN
  localparam logic [1:0] DRIVE = 2'd1;
`endif
  localparam logic [1:0] LOAD  = 2'd2;

  logic [1:0]         state;
  logic [1:0]         stateNxt;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    ptrNxt;
  logic [ID_W-1:0]    winId;
  logic [ID_W-1:0]    winIdNxt;
  logic [DST_W-1:0]   winDst;
  logic [DST_W-1:0]   winDstNxt;
  logic [ID_W-1:0]    reqWin;
  logic [DST_W-1:0]   reqDst;
  logic [NUM_SRC-1:0] enableNxt;
  logic [NUM_DST-1:0] loadNxt;
  logic [NUM_SRC-1:0] ackNxt;
  logic               busyNxt;
  logic [ID_W-1:0]    grantNxt;

  // First requesting source at or after the pointer, wrapping modulo NUM_SRC.
  function automatic logic [ID_W-1:0] pickWinner(input logic [NUM_SRC-1:0] req,
                                                 input logic [ID_W-1:0]    start);
    logic [ID_W-1:0] r;
    int              idx;
    r = start;
    for (int off = NUM_SRC - 1; off >= 0; off--) begin
      idx = int'(start) + off;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (req[ID_W'(idx)]) r = ID_W'(idx);
    end
    return r;
  endfunction

  function automatic logic [NUM_SRC-1:0] srcOneHot(input logic [ID_W-1:0] w);
    logic [NUM_SRC-1:0] r;
    for (int k = 0; k < NUM_SRC; k++) r[k] = (w == ID_W'(k));
    return r;
  endfunction

  // Indices at or beyond NUM_DST match no bit, so the strobe stays all zero.
  function automatic logic [NUM_DST-1:0] dstOneHot(input logic [DST_W-1:0] d);
    logic [NUM_DST-1:0] r;
    for (int k = 0; k < NUM_DST; k++) r[k] = (d == DST_W'(k));
    return r;
  endfunction

  function automatic logic [ID_W-1:0] nextPtr(input logic [ID_W-1:0] w);
    return (int'(w) == NUM_SRC - 1) ? '0 : w + ID_W'(1);
  endfunction

  assign reqWin = pickWinner(iReq, ptr);

  always_comb begin
    reqDst = '0;
    for (int k = 0; k < NUM_SRC; k++)
      if (reqWin == ID_W'(k)) reqDst = iDst[k*DST_W +: DST_W];
  end

  always_comb begin
    stateNxt  = state;
    ptrNxt    = ptr;
    winIdNxt  = winId;
    winDstNxt = winDst;
    grantNxt  = oGrantId;
    enableNxt = '0;
    loadNxt   = '0;
    ackNxt    = '0;
    busyNxt   = 1'b0;
    case (state)
      IDLE: begin
        if (|iReq) begin
          winIdNxt  = reqWin;
          winDstNxt = reqDst;
          grantNxt  = reqWin;
          enableNxt = srcOneHot(reqWin);
          busyNxt   = 1'b1;
`ifdef BUS_ARB_SETTLE_EN
          stateNxt  = DRIVE;
`else
          stateNxt  = LOAD;
          loadNxt   = dstOneHot(reqDst);
          ackNxt    = srcOneHot(reqWin);
          ptrNxt    = nextPtr(reqWin);
`endif
        end
      end
`ifdef BUS_ARB_SETTLE_EN
      // Bus has been driven a full cycle; the next cycle carries the load strobe.
      DRIVE: begin
        stateNxt  = LOAD;
        enableNxt = srcOneHot(winId);
        loadNxt   = dstOneHot(winDst);
        ackNxt    = srcOneHot(winId);
        busyNxt   = 1'b1;
        ptrNxt    = nextPtr(winId);
      end
`endif
      LOAD:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state    <= IDLE;
      ptr      <= '0;
      oEnable  <= '0;
      oLoad    <= '0;
      oAck     <= '0;
      oBusy    <= 1'b0;
      oGrantId <= '0;
    end else begin
      state    <= stateNxt;
      ptr      <= ptrNxt;
      oEnable  <= enableNxt;
      oLoad    <= loadNxt;
      oAck     <= ackNxt;
      oBusy    <= busyNxt;
      oGrantId <= grantNxt;
    end
  end

  // Latched transfer payload is only consumed after a grant, so it carries no reset.
  always_ff @(posedge iClk) begin
    winId  <= winIdNxt;
    winDst <= winDstNxt;
  end

endmodule
